// File: rtl/runner_session_ctrl.sv
// Runner session controller: tick generation, sample strobing, alarm and session FSM.
// Optional auto-pause on sustained zero steps: define RUNNER_AUTO_PAUSE_EN.
module runner_session_ctrl #(
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned MAX_SESSION_S = 255,
    parameter int unsigned EMERG_LIMIT   = 3,
    parameter int unsigned IDLE_TICKS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop_req,
    input  logic       pause_req,
    input  logic       resume_req,
    input  logic       sensor_valid,
    output logic       sensor_ready,
    input  logic [7:0] sensor_hr,
    input  logic [1:0] sensor_sps,
    output logic       calc_rst,
    output logic       calc_valid,
    output logic [7:0] calc_hr,
    output logic [1:0] calc_sps,
    input  logic [1:0] calc_class,
    output logic [2:0] state,
    output logic [7:0] ticks,
    output logic       alarm,
    output logic       session_done
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0] TICKS_MAX = 8'(MAX_SESSION_S);
    localparam logic [3:0] EMERG_MAX = 4'(EMERG_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_ALARM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        st;
    logic [CW-1:0] tick_cnt;
    logic [7:0]    hold_hr;
    logic [1:0]    hold_sps;
    logic          fresh;
    logic          sample_q;
    logic [3:0]    emerg;
    logic          running;
    logic          tick;
    logic          xfer;

    assign running = (st == S_RUN);
    assign tick    = running && (tick_cnt == TC_LAST);
    assign xfer    = sensor_valid && sensor_ready;
    assign state   = st;

`ifdef RUNNER_AUTO_PAUSE_EN
    localparam logic [7:0] IDLE_LIM = 8'(IDLE_TICKS);

    logic [7:0] zero_cnt;
    logic       auto_paused;

    assign sensor_ready = running || (st == S_PAUSE && auto_paused);
`else
    assign sensor_ready = running;

    // Without auto-pause the zero-step threshold has no effect.
    if (IDLE_TICKS > 255) begin : g_idle_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= S_IDLE;
            tick_cnt     <= '0;
            hold_hr      <= '0;
            hold_sps     <= '0;
            fresh        <= 1'b0;
            sample_q     <= 1'b0;
            emerg        <= '0;
            calc_rst     <= 1'b0;
            calc_valid   <= 1'b0;
            calc_hr      <= '0;
            calc_sps     <= '0;
            ticks        <= '0;
            alarm        <= 1'b0;
            session_done <= 1'b0;
`ifdef RUNNER_AUTO_PAUSE_EN
            zero_cnt     <= '0;
            auto_paused  <= 1'b0;
`endif
        end else begin
            calc_rst   <= 1'b0;
            calc_valid <= tick;
            sample_q   <= calc_valid;

            if (running) begin
                tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            end

            if (xfer) begin
                hold_hr  <= sensor_hr;
                hold_sps <= sensor_sps;
                fresh    <= 1'b1;
            end

            // A transfer landing in the tick cycle rides on this strobe.
            if (tick) begin
                calc_hr  <= xfer ? sensor_hr : hold_hr;
                calc_sps <= xfer ? sensor_sps : (fresh ? hold_sps : 2'd0);
                fresh    <= 1'b0;
            end

            if (calc_valid && ticks != TICKS_MAX) begin
                ticks <= ticks + 8'd1;
            end

            if (sample_q) begin
                if (calc_class == 2'b10) begin
                    emerg <= (emerg == 4'hf) ? emerg : emerg + 4'd1;
                end else begin
                    emerg <= '0;
                end
            end

`ifdef RUNNER_AUTO_PAUSE_EN
            if (calc_valid) begin
                if (calc_sps == 2'd0) begin
                    zero_cnt <= (zero_cnt == 8'hff) ? zero_cnt : zero_cnt + 8'd1;
                end else begin
                    zero_cnt <= '0;
                end
            end
`endif

            unique case (st)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        st           <= S_RUN;
                        calc_rst     <= 1'b1;
                        tick_cnt     <= '0;
                        hold_hr      <= '0;
                        hold_sps     <= '0;
                        fresh        <= 1'b0;
                        sample_q     <= 1'b0;
                        emerg        <= '0;
                        calc_valid   <= 1'b0;
                        calc_hr      <= '0;
                        calc_sps     <= '0;
                        ticks        <= '0;
                        alarm        <= 1'b0;
                        session_done <= 1'b0;
`ifdef RUNNER_AUTO_PAUSE_EN
                        zero_cnt     <= '0;
                        auto_paused  <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (stop_req) begin
                        st           <= S_DONE;
                        session_done <= 1'b1;
                    end else if (pause_req) begin
                        st <= S_PAUSE;
                    end else if (emerg == EMERG_MAX) begin
                        st    <= S_ALARM;
                        alarm <= 1'b1;
                    end else if (ticks == TICKS_MAX) begin
                        st           <= S_DONE;
                        session_done <= 1'b1;
`ifdef RUNNER_AUTO_PAUSE_EN
                    end else if (zero_cnt == IDLE_LIM) begin
                        st          <= S_PAUSE;
                        auto_paused <= 1'b1;
                        zero_cnt    <= '0;
`endif
                    end
                end
                S_PAUSE: begin
                    if (stop_req) begin
                        st           <= S_DONE;
                        session_done <= 1'b1;
                    end else if (resume_req) begin
                        st <= S_RUN;
`ifdef RUNNER_AUTO_PAUSE_EN
                        auto_paused <= 1'b0;
                        zero_cnt    <= '0;
                    end else if (auto_paused && xfer && sensor_sps != 2'd0) begin
                        st          <= S_RUN;
                        auto_paused <= 1'b0;
                        zero_cnt    <= '0;
`endif
                    end
                end
                S_ALARM: begin
                    if (stop_req) begin
                        st           <= S_DONE;
                        session_done <= 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_runner_session_ctrl.sv
// Directed bench for runner_session_ctrl with a strobe scoreboard.
// TICK_DIV=10, MAX_SESSION_S=8, EMERG_LIMIT=3; auto-pause steps under RUNNER_AUTO_PAUSE_EN.
module tb_runner_session_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop_req;
    logic       pause_req;
    logic       resume_req;
    logic       sensor_valid;
    logic       sensor_ready;
    logic [7:0] sensor_hr;
    logic [1:0] sensor_sps;
    logic       calc_rst;
    logic       calc_valid;
    logic [7:0] calc_hr;
    logic [1:0] calc_sps;
    logic [1:0] calc_class;
    logic [2:0] state;
    logic [7:0] ticks;
    logic       alarm;
    logic       session_done;

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;
    int nexp       = 0;
    int last_cyc   = 0;
    int cyc        = 0;
    int t0         = 0;
    int prev       = 0;
    int c0         = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    runner_session_ctrl #(
        .TICK_DIV(10),
        .MAX_SESSION_S(8),
        .EMERG_LIMIT(3),
        .IDLE_TICKS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop_req(stop_req),
        .pause_req(pause_req),
        .resume_req(resume_req),
        .sensor_valid(sensor_valid),
        .sensor_ready(sensor_ready),
        .sensor_hr(sensor_hr),
        .sensor_sps(sensor_sps),
        .calc_rst(calc_rst),
        .calc_valid(calc_valid),
        .calc_hr(calc_hr),
        .calc_sps(calc_sps),
        .calc_class(calc_class),
        .state(state),
        .ticks(ticks),
        .alarm(alarm),
        .session_done(session_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic go, input logic stp, input logic pse, input logic rsm);
        start      = go;
        stop_req   = stp;
        pause_req  = pse;
        resume_req = rsm;
        cyc1();
        start      = 1'b0;
        stop_req   = 1'b0;
        pause_req  = 1'b0;
        resume_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] hr, input logic [1:0] sps);
        sensor_valid = 1'b1;
        sensor_hr    = hr;
        sensor_sps   = sps;
        cyc1();
        sensor_valid = 1'b0;
    endtask

    task automatic expect_strobe(input logic [7:0] hr, input logic [1:0] sps);
        exp_q.push_back({hr, sps});
    endtask

    task automatic wait_strobe();
        int b = 0;
        nexp++;
        while (strobe_cnt < nexp && b < 40) begin
            cyc1();
            b++;
        end
        chk("strobe_count", strobe_cnt, nexp);
    endtask

    task automatic wait_cyc(input int target);
        int b = 0;
        while (cyc < target && b < 100) begin
            cyc1();
            b++;
        end
        chk("cycle_align", cyc, target);
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (calc_valid) begin
            strobe_cnt++;
            last_cyc = cyc;
            chk("strobe_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("strobe_hr", calc_hr, e[9:2]);
                chk("strobe_sps", calc_sps, e[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        stop_req     = 1'b0;
        pause_req    = 1'b0;
        resume_req   = 1'b0;
        sensor_valid = 1'b0;
        sensor_hr    = '0;
        sensor_sps   = '0;
        calc_class   = 2'b00;
        repeat (3) cyc1();
        chk("rst_state", state, 0);
        chk("rst_outputs", {calc_rst, calc_valid, sensor_ready, alarm,
                            session_done, ticks, calc_hr, calc_sps}, 0);
        rst = 1'b0;
        cyc1();
        chk("idle_after_rst", state, 0);

        // Full session: fresh sample every tick until the length limit.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        chk("start_state", state, 1);
        chk("start_calc_rst", calc_rst, 1);
        chk("ready_running", sensor_ready, 1);
        cyc1();
        chk("calc_rst_single", calc_rst, 0);
        for (int i = 0; i < 8; i++) begin
            expect_strobe(8'd120, 2'd2);
            send(8'd120, 2'd2);
            wait_strobe();
            if (i == 0) chk("first_strobe_latency", last_cyc - t0, 10);
            else chk("strobe_period", last_cyc - prev, 10);
            prev = last_cyc;
        end
        chk("ticks_limit", ticks, 8);
        cyc1();
        chk("done_state", state, 4);
        chk("done_flag", session_done, 1);
        chk("done_no_alarm", alarm, 0);
        repeat (25) cyc1();
        chk("no_strobe_in_done", strobe_cnt, nexp);

        // Stale strobes carry sps=0; a stop in the tick cycle keeps its strobe.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_ticks", ticks, 0);
        chk("restart_done_clr", session_done, 0);
        expect_strobe(8'd90, 2'd1);
        send(8'd90, 2'd1);
        wait_strobe();
        expect_strobe(8'd90, 2'd0);
        wait_strobe();
        expect_strobe(8'd90, 2'd0);
        wait_strobe();
        expect_strobe(8'd90, 2'd0);
        wait_cyc(last_cyc + 9);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_strobe();
        chk("stop_state", state, 4);
        chk("stop_ticks", ticks, 4);
        repeat (25) cyc1();
        chk("no_strobe_after_stop", strobe_cnt, nexp);

        // Three Emergency classifications raise the alarm.
        calc_class = 2'b10;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_clear_start", alarm, 0);
        for (int i = 0; i < 3; i++) begin
            expect_strobe(8'd0, 2'd0);
            wait_strobe();
        end
        repeat (3) cyc1();
        chk("alarm_state", state, 3);
        chk("alarm_flag", alarm, 1);
        chk("alarm_not_ready", sensor_ready, 0);
        repeat (20) cyc1();
        chk("no_strobe_in_alarm", strobe_cnt, nexp);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_ignores_start", state, 3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("alarm_stop_state", state, 4);
        chk("alarm_held_in_done", alarm, 1);
        chk("alarm_done_flag", session_done, 1);
        calc_class = 2'b00;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("alarm_cleared", alarm, 0);
        chk("alarm_restart_rst", calc_rst, 1);
        chk("alarm_restart_state", state, 1);

        // Pause at tick counter 4 freezes the tick, resume continues it.
        expect_strobe(8'd150, 2'd3);
        send(8'd150, 2'd3);
        wait_strobe();
        wait_cyc(last_cyc + 4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_state", state, 2);
        chk("pause_not_ready", sensor_ready, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_ignores_start", state, 2);
        repeat (48) cyc1();
        chk("no_strobe_paused", strobe_cnt, nexp);
        expect_strobe(8'd150, 2'd0);
        c0 = cyc;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_state", state, 1);
        wait_strobe();
        chk("resume_latency", last_cyc - c0, 6);

        // Simultaneous commands: stop wins.
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        chk("priority_stop", state, 4);
        chk("priority_done", session_done, 1);
        chk("priority_ticks", ticks, 2);

        // Reset mid-session abandons it and overrides start.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_state", state, 1);
        send(8'd33, 2'd1);
        cyc1();
        rst   = 1'b1;
        start = 1'b1;
        cyc1();
        start = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_outputs", {calc_rst, calc_valid, sensor_ready, alarm,
                                session_done, ticks, calc_hr, calc_sps}, 0);
        cyc1();
        rst = 1'b0;
        cyc1();
        chk("post_rst_idle", state, 0);
        repeat (20) cyc1();
        chk("no_strobe_after_rst", strobe_cnt, nexp);

`ifdef RUNNER_AUTO_PAUSE_EN
        // Five zero-step strobes auto-pause; a stepping sample resumes.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            expect_strobe(8'd0, 2'd0);
            wait_strobe();
        end
        repeat (2) cyc1();
        chk("auto_pause_state", state, 2);
        chk("auto_pause_ready", sensor_ready, 1);
        send(8'd77, 2'd1);
        chk("auto_resume_state", state, 1);
        expect_strobe(8'd77, 2'd1);
        wait_strobe();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("auto_stop_state", state, 4);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
